// File: rtl/pact_lsu_cmd_scheduler_if.sv
// ---------------------------------------------------------------------------
// pact_lsu_cmd_scheduler_if
//   Bundles the three handshakes of the PACT LSU command scheduler:
//     command side   : cmd_valid/cmd_ready/cmd_subop/cmd_immediate/cmd_tag
//     LSU node side  : lsu_start/lsu_subop/lsu_immediate/lsu_finish
//     completion side: done_valid/done_tag/done_error/done_cycles
//   plus the busy / num_pending status.
//   modport slave  : the scheduler's view.
//   modport master : the view of the environment driving the scheduler.
// ---------------------------------------------------------------------------
interface pact_lsu_cmd_scheduler_if #(
  parameter int BW_SUBOP     = 4,
  parameter int BW_IMMEDIATE = 32,
  parameter int BW_TAG       = 4,
  parameter int BW_CYCLE     = 16,
  parameter int BW_PENDING   = 3
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [BW_SUBOP-1:0]     cmd_subop;
  logic [BW_IMMEDIATE-1:0] cmd_immediate;
  logic [BW_TAG-1:0]       cmd_tag;
  logic                    lsu_start;
  logic [BW_SUBOP-1:0]     lsu_subop;
  logic [BW_IMMEDIATE-1:0] lsu_immediate;
  logic                    lsu_finish;
  logic                    done_valid;
  logic [BW_TAG-1:0]       done_tag;
  logic                    done_error;
  logic [BW_CYCLE-1:0]     done_cycles;
  logic                    busy;
  logic [BW_PENDING-1:0]   num_pending;

  modport slave (
    input  cmd_valid, cmd_subop, cmd_immediate, cmd_tag, lsu_finish,
    output cmd_ready, lsu_start, lsu_subop, lsu_immediate,
           done_valid, done_tag, done_error, done_cycles, busy, num_pending
  );

  modport master (
    output cmd_valid, cmd_subop, cmd_immediate, cmd_tag, lsu_finish,
    input  cmd_ready, lsu_start, lsu_subop, lsu_immediate,
           done_valid, done_tag, done_error, done_cycles, busy, num_pending
  );
endinterface

// File: rtl/pact_lsu_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// pact_lsu_cmd_scheduler
//   Command front-end of the PACT LSU node. Commands from the instruction
//   decoder are buffered in a FIFO_DEPTH-entry FIFO and issued one at a time
//   to the LSU node. Each command is retired with a completion record
//   (tag, latency, error). LOAD/STORE before any INFO, and IDLE-coded
//   commands, are rejected without reaching the node.
//
// Ports:
//   clk    : clock, rising edge
//   rstnn  : asynchronous active-low reset
//   bus    : pact_lsu_cmd_scheduler_if.slave
//            cmd_*   command offer / FIFO-not-full
//            lsu_*   one-cycle start pulse with subop/immediate, finish in
//            done_*  one-cycle completion record
//            busy, num_pending status
// ---------------------------------------------------------------------------
module pact_lsu_cmd_scheduler #(
  parameter int BW_SUBOP     = 4,
  parameter int BW_IMMEDIATE = 32,
  parameter int BW_TAG       = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int BW_CYCLE     = 16,
  parameter int SUBOP_IDLE   = 0,
  parameter int SUBOP_INFO   = 1,
  parameter int SUBOP_LOAD   = 2,
  parameter int SUBOP_STORE  = 3
) (
  input logic                     clk,
  input logic                     rstnn,
  pact_lsu_cmd_scheduler_if.slave bus
);

  localparam int BW_PTR = $clog2(FIFO_DEPTH);
  localparam int BW_CNT = BW_PTR + 1;

  localparam logic [BW_CNT-1:0]       CNT_ZERO   = {BW_CNT{1'b0}};
  localparam logic [BW_CNT-1:0]       CNT_FULL   = BW_CNT'(FIFO_DEPTH);
  localparam logic [BW_PTR-1:0]       PTR_ZERO   = {BW_PTR{1'b0}};
  localparam logic [BW_SUBOP-1:0]     SUBOP_ZERO = {BW_SUBOP{1'b0}};
  localparam logic [BW_IMMEDIATE-1:0] IMM_ZERO   = {BW_IMMEDIATE{1'b0}};
  localparam logic [BW_TAG-1:0]       TAG_ZERO   = {BW_TAG{1'b0}};
  localparam logic [BW_CYCLE-1:0]     CYC_ZERO   = {BW_CYCLE{1'b0}};
  localparam logic [BW_CYCLE-1:0]     CYC_ONE    = {{(BW_CYCLE-1){1'b0}}, 1'b1};
  localparam logic [BW_CYCLE-1:0]     CYC_MAX    = {BW_CYCLE{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RETIRE = 2'd3
  } state_t;

  // A command may reach the node unless it is IDLE-coded, or it is a
  // memory access while the memory-config register is still unconfigured.
  function automatic logic is_issuable(input logic [BW_SUBOP-1:0] subop,
                                       input logic                info_seen);
    logic is_mem;
    is_mem = (subop == BW_SUBOP'(SUBOP_LOAD)) | (subop == BW_SUBOP'(SUBOP_STORE));
    return (subop != BW_SUBOP'(SUBOP_IDLE)) & ~(is_mem & ~info_seen);
  endfunction

  logic [BW_SUBOP-1:0]     fifo_subop_r     [FIFO_DEPTH];
  logic [BW_IMMEDIATE-1:0] fifo_immediate_r [FIFO_DEPTH];
  logic [BW_TAG-1:0]       fifo_tag_r       [FIFO_DEPTH];
  logic [BW_PTR-1:0]       rd_ptr_r;
  logic [BW_PTR-1:0]       wr_ptr_r;
  logic [BW_CNT-1:0]       count_r;

  state_t                  state_r;
  logic                    info_seen_r;
  logic                    cur_info_r;
  logic [BW_TAG-1:0]       cur_tag_r;
  logic [BW_CYCLE-1:0]     cycle_cnt_r;
  logic                    lsu_start_r;
  logic [BW_SUBOP-1:0]     lsu_subop_r;
  logic [BW_IMMEDIATE-1:0] lsu_immediate_r;
  logic                    done_valid_r;
  logic [BW_TAG-1:0]       done_tag_r;
  logic                    done_error_r;
  logic [BW_CYCLE-1:0]     done_cycles_r;

  logic                    push_s;
  logic                    pop_s;
  logic                    enter_issue_s;
  logic                    head_issuable_s;
  logic [BW_SUBOP-1:0]     head_subop_s;
  logic [BW_IMMEDIATE-1:0] head_immediate_s;
  logic [BW_TAG-1:0]       head_tag_s;

  // FIFO handshake and head decode; the issue decision is taken one cycle
  // early (on entry to ISSUE) so lsu_start can come straight from a flop.
  // The head cannot change between that decision and the ISSUE pop since
  // only ISSUE pops.
  always_comb begin
    push_s           = bus.cmd_valid & (count_r != CNT_FULL);
    pop_s            = (state_r == ST_ISSUE);
    enter_issue_s    = ((state_r == ST_IDLE) | (state_r == ST_RETIRE)) & (count_r != CNT_ZERO);
    head_subop_s     = fifo_subop_r[rd_ptr_r];
    head_immediate_s = fifo_immediate_r[rd_ptr_r];
    head_tag_s       = fifo_tag_r[rd_ptr_r];
    head_issuable_s  = is_issuable(head_subop_s, info_seen_r);
  end

  // Command FIFO storage, pointers (wrap naturally, depth is a power of two)
  // and occupancy.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_subop_r[i]     <= SUBOP_ZERO;
        fifo_immediate_r[i] <= IMM_ZERO;
        fifo_tag_r[i]       <= TAG_ZERO;
      end
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        fifo_subop_r[wr_ptr_r]     <= bus.cmd_subop;
        fifo_immediate_r[wr_ptr_r] <= bus.cmd_immediate;
        fifo_tag_r[wr_ptr_r]       <= bus.cmd_tag;
        wr_ptr_r                   <= wr_ptr_r + 1'b1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Command sequencing FSM with registered LSU-side and completion outputs.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_r         <= ST_IDLE;
      info_seen_r     <= 1'b0;
      cur_info_r      <= 1'b0;
      cur_tag_r       <= TAG_ZERO;
      cycle_cnt_r     <= CYC_ZERO;
      lsu_start_r     <= 1'b0;
      lsu_subop_r     <= SUBOP_ZERO;
      lsu_immediate_r <= IMM_ZERO;
      done_valid_r    <= 1'b0;
      done_tag_r      <= TAG_ZERO;
      done_error_r    <= 1'b0;
      done_cycles_r   <= CYC_ZERO;
    end else begin
      // Start pulse and its payload live only during the ISSUE cycle.
      lsu_start_r     <= enter_issue_s & head_issuable_s;
      lsu_subop_r     <= (enter_issue_s & head_issuable_s) ? head_subop_s : SUBOP_ZERO;
      lsu_immediate_r <= (enter_issue_s & head_issuable_s) ? head_immediate_s : IMM_ZERO;
      // Completion record is a single-cycle pulse unless set below.
      done_valid_r    <= 1'b0;
      done_tag_r      <= TAG_ZERO;
      done_error_r    <= 1'b0;
      done_cycles_r   <= CYC_ZERO;

      case (state_r)
        ST_IDLE: begin
          if (enter_issue_s) begin
            state_r <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          cur_tag_r  <= head_tag_s;
          cur_info_r <= (head_subop_s == BW_SUBOP'(SUBOP_INFO));
          if (lsu_start_r) begin
            state_r     <= ST_WAIT;
            cycle_cnt_r <= CYC_ONE;
          end else begin
            state_r       <= ST_RETIRE;
            done_valid_r  <= 1'b1;
            done_tag_r    <= head_tag_s;
            done_error_r  <= 1'b1;
            done_cycles_r <= CYC_ZERO;
          end
        end
        ST_WAIT: begin
          if (bus.lsu_finish) begin
            state_r       <= ST_RETIRE;
            done_valid_r  <= 1'b1;
            done_tag_r    <= cur_tag_r;
            done_error_r  <= 1'b0;
            done_cycles_r <= cycle_cnt_r;
            info_seen_r   <= info_seen_r | cur_info_r;
          end else if (cycle_cnt_r != CYC_MAX) begin
            cycle_cnt_r <= cycle_cnt_r + 1'b1;
          end else begin
            cycle_cnt_r <= cycle_cnt_r;
          end
        end
        ST_RETIRE: begin
          if (enter_issue_s) begin
            state_r <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs are decoded purely from registered state.
  assign bus.cmd_ready     = (count_r != CNT_FULL);
  assign bus.busy          = (count_r != CNT_ZERO) | (state_r != ST_IDLE);
  assign bus.num_pending   = count_r;
  assign bus.lsu_start     = lsu_start_r;
  assign bus.lsu_subop     = lsu_subop_r;
  assign bus.lsu_immediate = lsu_immediate_r;
  assign bus.done_valid    = done_valid_r;
  assign bus.done_tag      = done_tag_r;
  assign bus.done_error    = done_error_r;
  assign bus.done_cycles   = done_cycles_r;

endmodule

// File: tb/tb_pact_lsu_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pact_lsu_cmd_scheduler
//   Directed scenarios followed by randomized traffic. A queue-based
//   reference model predicts every output each cycle; an LSU-node emulator
//   returns lsu_finish a chosen number of cycles after each observed start.
// ---------------------------------------------------------------------------
module tb_pact_lsu_cmd_scheduler;

  localparam int DEPTH    = 4;
  localparam int BW_CYC   = 16;
  localparam int CYC_MAX  = 65535;
  localparam int S_IDLE   = 0;
  localparam int S_INFO   = 1;
  localparam int S_LOAD   = 2;
  localparam int S_STORE  = 3;

  typedef struct packed {
    logic [3:0]  subop;
    logic [31:0] imm;
    logic [3:0]  tag;
  } cmd_t;

  logic clk;
  logic rstnn;

  pact_lsu_cmd_scheduler_if #(
    .BW_SUBOP(4), .BW_IMMEDIATE(32), .BW_TAG(4), .BW_CYCLE(BW_CYC), .BW_PENDING(3)
  ) bus_if ();

  pact_lsu_cmd_scheduler #(
    .BW_SUBOP(4), .BW_IMMEDIATE(32), .BW_TAG(4), .FIFO_DEPTH(DEPTH), .BW_CYCLE(BW_CYC),
    .SUBOP_IDLE(S_IDLE), .SUBOP_INFO(S_INFO), .SUBOP_LOAD(S_LOAD), .SUBOP_STORE(S_STORE)
  ) dut (
    .clk   (clk),
    .rstnn (rstnn),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the queue is the FIFO content; the scheduler is
  // described by what it is doing this cycle.
  localparam int PH_IDLE   = 0;  // nothing being handled
  localparam int PH_EXAM   = 1;  // head under examination, maybe starting
  localparam int PH_FLIGHT = 2;  // command out at the node
  localparam int PH_DONE   = 3;  // completion record shown
  cmd_t q[$];
  int   m_phase;
  bit   m_info_seen;
  cmd_t m_cur;
  int   m_elapsed;
  int   m_done_tag;
  int   m_done_err;
  int   m_done_cyc;

  // LSU node emulator state
  int age = -1;
  int cur_delay = 1;
  int fixed_delay = 1;
  bit rand_delay_en = 1'b0;
  bit noise_en = 1'b0;
  bit fin_now = 1'b0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit may_issue(input logic [3:0] s, input bit info);
    if (s == 4'(S_IDLE)) return 1'b0;
    if ((s == 4'(S_LOAD) || s == 4'(S_STORE)) && !info) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_phase     = PH_IDLE;
    m_info_seen = 1'b0;
    m_elapsed   = 0;
  endtask

  task automatic model_step(input bit v, input cmd_t c, input bit fin);
    bit accept;
    accept = v && (q.size() != DEPTH);
    case (m_phase)
      PH_IDLE: if (q.size() != 0) m_phase = PH_EXAM;
      PH_EXAM: begin
        m_cur = q.pop_front();
        if (may_issue(m_cur.subop, m_info_seen)) begin
          m_phase   = PH_FLIGHT;
          m_elapsed = 1;
        end else begin
          m_phase    = PH_DONE;
          m_done_tag = int'(m_cur.tag);
          m_done_err = 1;
          m_done_cyc = 0;
        end
      end
      PH_FLIGHT: begin
        if (fin) begin
          m_phase    = PH_DONE;
          m_done_tag = int'(m_cur.tag);
          m_done_err = 0;
          m_done_cyc = m_elapsed;
          if (m_cur.subop == 4'(S_INFO)) m_info_seen = 1'b1;
        end else if (m_elapsed < CYC_MAX) begin
          m_elapsed++;
        end
      end
      default: m_phase = (q.size() != 0) ? PH_EXAM : PH_IDLE;
    endcase
    if (accept) q.push_back(c);
  endtask

  task automatic check_all();
    bit   exp_start;
    cmd_t head;
    exp_start = 1'b0;
    head      = '0;
    if (m_phase == PH_EXAM) begin
      head      = q[0];
      exp_start = may_issue(head.subop, m_info_seen);
    end
    check_value("cmd_ready", bus_if.cmd_ready, q.size() != DEPTH);
    check_value("num_pending", bus_if.num_pending, q.size());
    check_value("busy", bus_if.busy, (q.size() != 0) || (m_phase != PH_IDLE));
    check_value("lsu_start", bus_if.lsu_start, exp_start);
    check_value("lsu_subop", bus_if.lsu_subop, exp_start ? head.subop : 4'h0);
    check_value("lsu_immediate", bus_if.lsu_immediate, exp_start ? head.imm : 32'h0);
    check_value("done_valid", bus_if.done_valid, m_phase == PH_DONE);
    if (m_phase == PH_DONE) begin
      check_value("done_tag", bus_if.done_tag, m_done_tag);
      check_value("done_error", bus_if.done_error, m_done_err);
      check_value("done_cycles", bus_if.done_cycles, m_done_cyc);
    end
  endtask

  // One clock cycle: drive inputs, step model at the edge, check #1 later,
  // then plan the node's finish for the following cycle.
  task automatic cycle(input bit v, input logic [3:0] s, input logic [31:0] imm, input logic [3:0] t);
    cmd_t c;
    c = '{subop: s, imm: imm, tag: t};
    bus_if.cmd_valid     = v;
    bus_if.cmd_subop     = s;
    bus_if.cmd_immediate = imm;
    bus_if.cmd_tag       = t;
    bus_if.lsu_finish    = fin_now;
    @(posedge clk);
    model_step(v, c, fin_now);
    #1;
    check_all();
    if (bus_if.lsu_start) begin
      age       = 0;
      cur_delay = rand_delay_en ? int'($urandom_range(1, 6)) : fixed_delay;
    end else if (age >= 0) begin
      age++;
    end
    fin_now = 1'b0;
    if (age >= 1 && age == cur_delay) begin
      fin_now = 1'b1;
      age     = -1;
    end
    if (noise_en && $urandom_range(0, 7) == 0) fin_now = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 32'h0, 4'h0);
  endtask

  // Asynchronous reset asserted mid-cycle, held over two edges.
  task automatic do_reset();
    #2;
    rstnn = 1'b0;
    bus_if.cmd_valid  = 1'b0;
    bus_if.lsu_finish = 1'b0;
    fin_now = 1'b0;
    age     = -1;
    #1;
    model_reset();
    check_all();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all();
    end
    #2;
    rstnn = 1'b1;
  endtask

  task automatic push_series(input int n, input logic [3:0] s);
    int t;
    int guard;
    bit acc;
    t = 0;
    guard = 0;
    while (t < n && guard < 200) begin
      acc = bus_if.cmd_ready;
      cycle(1'b1, s, 32'h100 + 32'(t), 4'(t));
      if (acc) t++;
      guard++;
    end
    check_value("push_series_done", t, n);
  endtask

  initial begin
    rstnn = 1'b0;
    bus_if.cmd_valid     = 1'b0;
    bus_if.cmd_subop     = 4'h0;
    bus_if.cmd_immediate = 32'h0;
    bus_if.cmd_tag       = 4'h0;
    bus_if.lsu_finish    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #2;
    rstnn = 1'b1;

    // LOAD before any INFO is rejected
    cycle(1'b1, 4'(S_LOAD), 32'h10, 4'h3);
    idle(4);

    // INFO with finish one cycle after start, then LOAD with 20-cycle latency
    fixed_delay = 1;
    cycle(1'b1, 4'(S_INFO), 32'h1234, 4'h1);
    idle(5);
    fixed_delay = 20;
    cycle(1'b1, 4'(S_LOAD), 32'h55, 4'h2);
    idle(26);

    // Fill the FIFO while the node is slow; drain in order
    fixed_delay = 30;
    push_series(6, 4'(S_STORE));
    idle(220);

    // Other subops issue regardless; IDLE subop is rejected
    fixed_delay = 2;
    cycle(1'b1, 4'h7, 32'hABCD, 4'h9);
    cycle(1'b1, 4'(S_IDLE), 32'h0, 4'hA);
    idle(10);

    // Latency counter saturation
    fixed_delay = 70000;
    cycle(1'b1, 4'(S_INFO), 32'h77, 4'h5);
    idle(70010);

    // Reset during WAIT with two commands queued; LOAD rejected afterwards
    fixed_delay = 50;
    cycle(1'b1, 4'(S_INFO), 32'h1, 4'h1);
    cycle(1'b1, 4'(S_STORE), 32'h2, 4'h2);
    cycle(1'b1, 4'(S_LOAD), 32'h3, 4'h3);
    idle(3);
    do_reset();
    cycle(1'b1, 4'(S_LOAD), 32'h4, 4'h4);
    idle(5);

    // Randomized traffic with random node latency and stray finishes
    rand_delay_en = 1'b1;
    noise_en      = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [3:0] s;
      r = int'($urandom_range(0, 9));
      if (r == 0)      s = 4'(S_IDLE);
      else if (r <= 2) s = 4'(S_INFO);
      else if (r <= 5) s = 4'(S_LOAD);
      else if (r <= 7) s = 4'(S_STORE);
      else             s = 4'($urandom_range(4, 15));
      cycle($urandom_range(0, 1) == 1, s, $urandom, 4'($urandom_range(0, 15)));
      if (i == 1500) do_reset();
    end
    rand_delay_en = 1'b0;
    noise_en      = 1'b0;
    fixed_delay   = 3;
    idle(60);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
